// File: rtl/start_signal_sequencer.sv
// Polls the start-signal PIO, debounces the start bit and sequences
// one camera capture per qualified rising edge, with timeout tracking.
module start_signal_sequencer #(
    parameter int POLL_INTERVAL  = 1024,
    parameter int DEBOUNCE_COUNT = 4,
    parameter int TIMEOUT_CYCLES = 1 << 24,
    parameter int START_BIT      = 0,
    parameter int CNT_W          = 24
) (
    input  logic        clk,
    input  logic        reset,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        capture_start,
    input  logic        capture_done,
    output logic        capture_busy,
    output logic [15:0] sample_value,
    output logic        sample_valid,
    output logic        start_level,
    output logic        status_timeout,
    output logic        status_overrun,
    input  logic        clear_status
);

    localparam int DB_W = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [CNT_W-1:0] POLL_LOAD = CNT_W'(POLL_INTERVAL - 1);
    localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE_COUNT);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] poll_cnt;
    logic [CNT_W-1:0] to_cnt, to_nxt;
    logic             rd_q;
    logic             cand, cand_nxt;
    logic [DB_W-1:0]  stab, stab_nxt;
    logic             level_nxt;
    logic             rise;
    logic             sample_bit;
    logic             start_nxt;
    logic             to_set;
    logic             ov_set;
    logic             unused_hi;

    assign avm_address  = 2'b00;
    assign avm_read     = (poll_cnt == '0) && !reset;
    assign capture_busy = (state == BUSY);
    assign sample_bit   = avm_readdata[START_BIT];
    assign unused_hi    = ^avm_readdata[31:16];

    // Debounce: the stable count tracks the current run of equal samples.
    always_comb begin
        cand_nxt  = cand;
        stab_nxt  = stab;
        level_nxt = start_level;
        if (rd_q) begin
            if (sample_bit == cand) begin
                if (stab != DB_MAX) begin
                    stab_nxt = stab + DB_W'(1);
                end
            end else begin
                cand_nxt = sample_bit;
                stab_nxt = DB_W'(1);
            end
            if (stab_nxt == DB_MAX) begin
                level_nxt = cand_nxt;
            end
        end
    end

    assign rise = level_nxt && !start_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_nxt;
        end
    end

    // Done has priority over an expiring timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        to_nxt    = to_cnt;
        start_nxt = 1'b0;
        to_set    = 1'b0;
        ov_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = BUSY;
                    to_nxt    = TO_LOAD;
                    start_nxt = 1'b1;
                end
            end
            BUSY: begin
                if (rise) begin
                    ov_set = 1'b1;
                end
                if (capture_done) begin
                    state_nxt = IDLE;
                end else if (to_cnt == '0) begin
                    state_nxt = IDLE;
                    to_set    = 1'b1;
                end else begin
                    to_nxt = to_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            poll_cnt       <= POLL_LOAD;
            rd_q           <= 1'b0;
            cand           <= 1'b0;
            stab           <= '0;
            start_level    <= 1'b0;
            sample_value   <= '0;
            sample_valid   <= 1'b0;
            capture_start  <= 1'b0;
            status_timeout <= 1'b0;
            status_overrun <= 1'b0;
        end else begin
            poll_cnt       <= (poll_cnt == '0) ? POLL_LOAD
                                               : poll_cnt - CNT_W'(1);
            rd_q           <= avm_read;
            cand           <= cand_nxt;
            stab           <= stab_nxt;
            start_level    <= level_nxt;
            sample_valid   <= rd_q;
            if (rd_q) begin
                sample_value <= avm_readdata[15:0];
            end
            capture_start  <= start_nxt;
            status_timeout <= to_set | (status_timeout & ~clear_status);
            status_overrun <= ov_set | (status_overrun & ~clear_status);
        end
    end

endmodule

// File: tb/tb_start_signal_sequencer.sv
// Randomized and directed checks of start_signal_sequencer against an
// event-level model (poll schedule, sample history, capture deadlines).
module tb_start_signal_sequencer;

    localparam int P  = 4;
    localparam int D  = 3;
    localparam int T  = 32;
    localparam int SB = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata = '0;
    logic        capture_start;
    logic        capture_done = 1'b0;
    logic        capture_busy;
    logic [15:0] sample_value;
    logic        sample_valid;
    logic        start_level;
    logic        status_timeout;
    logic        status_overrun;
    logic        clear_status = 1'b0;

    always #5 clk = ~clk;

    start_signal_sequencer #(
        .POLL_INTERVAL (P),
        .DEBOUNCE_COUNT(D),
        .TIMEOUT_CYCLES(T),
        .START_BIT     (SB),
        .CNT_W         (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .avm_address   (avm_address),
        .avm_read      (avm_read),
        .avm_readdata  (avm_readdata),
        .capture_start (capture_start),
        .capture_done  (capture_done),
        .capture_busy  (capture_busy),
        .sample_value  (sample_value),
        .sample_valid  (sample_valid),
        .start_level   (start_level),
        .status_timeout(status_timeout),
        .status_overrun(status_overrun),
        .clear_status  (clear_status)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: values visible in the current cycle.
    int        cyc;
    bit        rd_prev;
    bit [15:0] m_sv;
    bit        m_svalid, m_level, m_busy, m_start, m_to, m_ov;
    int        deadline;
    bit        hist[$];
    int        m_nsamp = 0;
    int        last_cyc;
    int        n_starts = 0;
    logic [15:0] in_port = '0;

    function automatic void mdl_reset();
        cyc      = 0;
        rd_prev  = 1'b0;
        m_sv     = '0;
        m_svalid = 1'b0;
        m_level  = 1'b0;
        m_busy   = 1'b0;
        m_start  = 1'b0;
        m_to     = 1'b0;
        m_ov     = 1'b0;
        deadline = 0;
        hist.delete();
    endfunction

    task automatic step(input bit r, input bit dn, input bit cl);
        bit          exp_rd, rise, nl, all_eq, n_start, to_set, ov_set;
        bit [15:0]   n_sv;
        bit          n_svalid;
        logic [24:0] obs, expv;
        @(posedge clk);
        #1;
        reset        = r;
        capture_done = dn;
        clear_status = cl;
        avm_readdata = rd_prev ? {16'($urandom), in_port} : 32'($urandom);
        #1;
        exp_rd = !r && (cyc % P == P - 1);
        obs  = {avm_address, avm_read, capture_start, capture_busy,
                start_level, sample_valid, status_timeout, status_overrun,
                sample_value};
        expv = {2'b00, exp_rd, m_start, m_busy, m_level, m_svalid,
                m_to, m_ov, m_sv};
        chk($sformatf("outs@%0d", cyc), 32'(obs), 32'(expv));
        if (capture_start === 1'b1) n_starts++;
        last_cyc = cyc;
        if (r) begin
            mdl_reset();
            return;
        end
        rise     = 1'b0;
        nl       = m_level;
        n_sv     = m_sv;
        n_svalid = 1'b0;
        if (rd_prev) begin
            n_sv     = in_port;
            n_svalid = 1'b1;
            m_nsamp++;
            hist.push_back(in_port[SB]);
            if (hist.size() > D) void'(hist.pop_front());
            if (hist.size() == D) begin
                all_eq = 1'b1;
                foreach (hist[i]) if (hist[i] != hist[0]) all_eq = 1'b0;
                if (all_eq) nl = hist[0];
            end
            rise = nl && !m_level;
        end
        n_start = 1'b0;
        to_set  = 1'b0;
        ov_set  = 1'b0;
        if (m_busy) begin
            if (rise) ov_set = 1'b1;
            if (dn) m_busy = 1'b0;
            else if (cyc == deadline) begin
                m_busy = 1'b0;
                to_set = 1'b1;
            end
        end else if (rise) begin
            m_busy   = 1'b1;
            n_start  = 1'b1;
            deadline = cyc + T;
        end
        m_to     = to_set | (m_to & !cl);
        m_ov     = ov_set | (m_ov & !cl);
        m_start  = n_start;
        m_level  = nl;
        m_sv     = n_sv;
        m_svalid = n_svalid;
        rd_prev  = exp_rd;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic qual(input bit b);
        int s0, k;
        in_port[SB] = b;
        s0 = m_nsamp;
        k  = 0;
        while (m_nsamp < s0 + D && k < 100) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
    endtask

    task automatic wait_start(output int s);
        s = -1;
        for (int k = 0; k < 200; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (capture_start === 1'b1) begin
                s = last_cyc;
                break;
            end
        end
        chk("start_seen", 32'(s >= 0), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          reads[$];
        int          s, s0, k, pat[6];
        logic [15:0] sv13;
        logic        busy13, lvl13;
        logic [24:0] zv;
        bit          r, dn, cl;

        mdl_reset();
        s = -1;
        sv13 = 'x;
        busy13 = 1'bx;
        lvl13 = 1'bx;

        // Constant start request from reset.
        in_port = 16'h0001;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (avm_read === 1'b1) reads.push_back(last_cyc);
            if (capture_start === 1'b1 && s < 0) s = last_cyc;
            if (last_cyc == 13) begin
                sv13   = sample_value;
                busy13 = capture_busy;
                lvl13  = start_level;
            end
        end
        chk("read0", 32'(reads.size() > 0 ? reads[0] : -1), 32'd3);
        chk("read1", 32'(reads.size() > 1 ? reads[1] : -1), 32'd7);
        chk("read2", 32'(reads.size() > 2 ? reads[2] : -1), 32'd11);
        chk("start_cyc", 32'(s), 32'd13);
        chk("sv13", 32'(sv13), 32'h1);
        chk("busy13", 32'(busy13), 32'd1);
        chk("lvl13", 32'(lvl13), 32'd1);

        // Completion five cycles after the start pulse.
        while (cyc < s + 5) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("busy_after_done", 32'(capture_busy), 32'd0);
        chk("to_after_done", 32'(status_timeout), 32'd0);

        // Bouncy start pattern 1,1,0,1,1,1.
        in_port = '0;
        repeat (2) step(1'b1, 1'b0, 1'b0);
        pat = '{1, 1, 0, 1, 1, 1};
        s0 = n_starts;
        foreach (pat[i]) begin
            in_port[SB] = pat[i][0];
            k = m_nsamp;
            for (int j = 0; j < 20 && m_nsamp == k; j++)
                step(1'b0, 1'b0, 1'b0);
        end
        chk("pre_starts", 32'(n_starts - s0), 32'd0);
        run(8);
        chk("post_starts", 32'(n_starts - s0), 32'd1);
        step(1'b0, 1'b1, 1'b0);

        // Timeout with no completion, then clear.
        qual(1'b0);
        in_port[SB] = 1'b1;
        wait_start(s);
        k = 0;
        while (capture_busy === 1'b1 && k < 100) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
        chk("to_len", 32'(k), 32'(T));
        chk("to_flag", 32'(status_timeout), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("to_clr", 32'(status_timeout), 32'd0);

        // Second qualified edge while busy.
        qual(1'b0);
        in_port[SB] = 1'b1;
        wait_start(s);
        s0 = n_starts;
        qual(1'b0);
        qual(1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("ovr_starts", 32'(n_starts - s0), 32'd0);
        chk("ovr_busy", 32'(capture_busy), 32'd1);
        chk("ovr_flag", 32'(status_overrun), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Done on the exact timeout cycle.
        qual(1'b0);
        in_port[SB] = 1'b1;
        wait_start(s);
        while (cyc < s + T - 1) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("busy_dl", 32'(capture_busy), 32'd0);
        chk("to_dl", 32'(status_timeout), 32'd0);

        // Reset in the middle of a capture.
        qual(1'b0);
        in_port[SB] = 1'b1;
        wait_start(s);
        run(3);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        zv = {avm_address, avm_read, capture_start, capture_busy,
              start_level, sample_valid, status_timeout, status_overrun,
              sample_value};
        chk("rst_outs", 32'(zv), 32'd0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            in_port[15:1] = 15'($urandom);
            if ($urandom_range(0, 19) == 0) in_port[SB] = ~in_port[SB];
            if (m_busy && cyc == deadline) dn = 1'($urandom_range(0, 1));
            else dn = ($urandom_range(0, 9) == 0);
            cl = ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 499) == 0);
            step(r, dn, cl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
